jstk_spi_responder: RTL and testbench
=====================================

# jstk_spi_responder

SPI slave that emulates the PmodJSTK joystick on the far end of the joystick SPI link. Driven by `joystick_top`'s master signals, it returns a 5-byte position/button frame and captures the LED command byte the master sends. It is used in simulation benches and on a second board, so `joystick_top` and `screen_top` can be exercised without the physical Pmod.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on `jstk_SS` / `jstk_SCLK` / `jstk_MOSI` (≥2).
- `clk` input 1: system clock; must be ≥8× SCLK frequency.
- `rst` input 1: asynchronous, active-low reset.
- `jstk_SS` input 1: slave select from the master, active-low.
- `jstk_SCLK` input 1: SPI clock from the master, mode 0 (CPOL=0, CPHA=0).
- `jstk_MOSI` input 1: master→slave data, MSB first.
- `jstk_MISO` output 1: slave→master data, MSB first.
- `x_pos` input 10: X position, snapshotted at frame start.
- `y_pos` input 10: Y position, snapshotted at frame start.
- `buttons` input 3: {btn2, btn1, stick_press}, snapshotted at frame start.
- `led_cmd` output 2: last valid LED command {led2, led1}.
- `frame_done` output 1: one-cycle pulse when a well-formed 40-bit frame ends.
- `frame_error` output 1: one-cycle pulse when a frame ends with bit count ≠ 40.

## Operation
- Response frame, in byte order: B0 = x_pos[7:0]; B1 = {6'b0, x_pos[9:8]}; B2 = y_pos[7:0]; B3 = {6'b0, y_pos[9:8]}; B4 = {5'b0, buttons}.
- Command frame: B0 = {6'b100000, led2, led1}. B1–B4 are don't-care.
- Synchronizer: all three SPI inputs pass through `SYNC_STAGES` flops. Edges are detected on the synchronized SS and SCLK.
- FSM states:
  - WAIT_IDLE: entered from reset. Go to IDLE once synced SS = 1. This ensures a frame already in progress at reset release is ignored.
  - IDLE: `jstk_MISO` = 0. On SS falling edge: snapshot inputs into a 40-bit shift register, clear `bit_cnt` (6 bits), drive MISO = B0[7], go to ACTIVE.
  - ACTIVE, SCLK rising edge: shift synced MOSI into an 8-bit rx register and increment `bit_cnt`, saturating at 63.
  - ACTIVE, SCLK falling edge: shift the tx register left, filling with 0, and drive the next MSB on MISO. Bits past 40 read 0.
  - ACTIVE, SS rising edge:
    - `bit_cnt` = 40: pulse `frame_done`. If B0[7:2] = 6'b100000, update `led_cmd` ← B0[1:0].
    - `bit_cnt` ≠ 40: pulse `frame_error`; `led_cmd` is unchanged.
    - Either way, return to IDLE.
- B0 rx byte is latched when `bit_cnt` reaches 8.
- SCLK edges while SS is high are ignored.
- If an SS rising edge and an SCLK edge are seen in the same cycle, the SS edge wins and the SCLK edge is dropped.

## Timing
- Reset values: `jstk_MISO` = 0, `led_cmd` = 2'b00, `frame_done` = 0, `frame_error` = 0, FSM = WAIT_IDLE, all counters and shift registers 0.
- Input-to-edge-detect latency is `SYNC_STAGES`+1 clk.
- MISO is valid `SYNC_STAGES`+2 clk after the SS or SCLK edge that causes it. The master must leave ≥4 clk between SS falling and the first SCLK rise, and keep SCLK half-period ≥4 clk.
- `frame_done` / `frame_error` assert `SYNC_STAGES`+2 clk after SS rises. When `frame_done` pulses, `led_cmd` updates in the same cycle.
- Inputs are snapshotted once per frame; changes mid-frame do not affect the current frame.

## Structure
- Package `jstk_pkg` holds:
  - `FRAME_BITS` = 40
  - `LED_HDR` = 6'b100000
  - the FSM state enum {WAIT_IDLE, IDLE, ACTIVE}
  - a function that packs x/y/buttons into the 40-bit frame.
- Sub-module `spi_in_sync`: parameterised synchronizer plus rise/fall edge detect, instantiated for SS and SCLK. MOSI uses the sync path only.

## Test plan
- **Nominal frame:** x=10'h2A5, y=10'h13C, buttons=3'b101; master sends 0x83, 0, 0, 0, 0. Master must read A5, 02, 3C, 01, 05. Expect `frame_done` pulse and `led_cmd` = 2'b11.
- **Bad header:** master sends B0 = 0x43. Bytes are returned correctly and `frame_done` pulses, but `led_cmd` keeps its prior value.
- **Short frame:** SS rises after 20 bits. Expect a `frame_error` pulse, no `frame_done`, `led_cmd` unchanged, and the next full frame succeeds.
- **Long frame:** 48 bits clocked. Bits 41–48 read 0 and `frame_error` pulses.
- **Mid-frame input change:** x_pos changes from 10'h001 to 10'h3FF after byte 1. Master still reads 01, 00 for the X bytes.
- **Reset mid-frame:** `rst` is asserted low during byte 2, with SS still low at release. No pulse occurs and MISO = 0 until SS goes high. A following frame returns correct data.

Source files
------------

// File: rtl/jstk_pkg.sv
// Shared constants, FSM state type and frame packing for the PmodJSTK SPI responder.
package jstk_pkg;

  localparam int         FRAME_BITS = 40;
  localparam logic [5:0] LED_HDR    = 6'b100000;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    ACTIVE
  } jstk_state_e;

  // Byte 0 lands in the top bits so the frame can be shifted out MSB first.
  function automatic logic [FRAME_BITS-1:0] pack_frame(
    input logic [9:0] x,
    input logic [9:0] y,
    input logic [2:0] btn
  );
    return {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 5'b0, btn};
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchronizer for one asynchronous SPI line, with registered rise/fall strobes.
module spi_in_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              q_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= '0;
      q_d   <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      q_d   <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~q_d;
      fall  <= ~chain[STAGES-1] & q_d;
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/jstk_spi_responder.sv
// SPI mode-0 slave emulating the PmodJSTK: returns a 5-byte position/button frame
// and captures the LED command carried in the first byte the master sends.
module jstk_spi_responder
  import jstk_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jstk_SS,
  input  logic        jstk_SCLK,
  input  logic        jstk_MOSI,
  output logic        jstk_MISO,
  input  logic [9:0]  x_pos,
  input  logic [9:0]  y_pos,
  input  logic [2:0]  buttons,
  output logic [1:0]  led_cmd,
  output logic        frame_done,
  output logic        frame_error,
  output jstk_state_e dbg_state
);

  logic ss_s, ss_rise, ss_fall;
  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_s;

  spi_in_sync #(.STAGES(SYNC_STAGES)) u_ss_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (jstk_SS),
    .q    (ss_s),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (jstk_SCLK),
    .q    (sclk_level_unused),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  // MOSI is only sampled on SCLK rise, long after it settled, so no edge logic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mosi_sync <= '0;
    else      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], jstk_MOSI};
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  jstk_state_e state, state_next;
  logic        load, shift_rx, shift_tx, end_frame;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= WAIT_IDLE;
    else      state <= state_next;
  end

  // An SS rise in ACTIVE suppresses any SCLK edge seen in the same cycle.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift_rx   = 1'b0;
    shift_tx   = 1'b0;
    end_frame  = 1'b0;
    case (state)
      WAIT_IDLE: if (ss_s) state_next = IDLE;
      IDLE: begin
        if (ss_fall) begin
          load       = 1'b1;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          end_frame  = 1'b1;
          state_next = IDLE;
        end else begin
          shift_rx = sclk_rise;
          shift_tx = sclk_fall;
        end
      end
      default: state_next = WAIT_IDLE;
    endcase
  end

  assign dbg_state = state;

  logic [FRAME_BITS-1:0] snap;
  logic [FRAME_BITS-1:0] tx_sr;
  logic [7:0]            rx_sr;
  logic [7:0]            rx_b0;
  logic [5:0]            bit_cnt;
  logic                  len_ok;

  assign snap   = pack_frame(x_pos, y_pos, buttons);
  assign len_ok = (bit_cnt == 6'(FRAME_BITS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_sr       <= '0;
      rx_sr       <= '0;
      rx_b0       <= '0;
      bit_cnt     <= '0;
      jstk_MISO   <= 1'b0;
      led_cmd     <= 2'b00;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_done  <= end_frame & len_ok;
      frame_error <= end_frame & ~len_ok;
      if (load) begin
        tx_sr     <= snap;
        rx_sr     <= '0;
        rx_b0     <= '0;
        bit_cnt   <= '0;
        jstk_MISO <= snap[FRAME_BITS-1];
      end
      if (shift_rx) begin
        rx_sr <= {rx_sr[6:0], mosi_s};
        if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
      end
      // Holds the first received byte once eight bits are in; rx_sr is stable meanwhile.
      if (!load && bit_cnt == 6'd8) rx_b0 <= rx_sr;
      if (shift_tx) begin
        tx_sr     <= tx_sr << 1;
        jstk_MISO <= tx_sr[FRAME_BITS-2];
      end
      if (end_frame) begin
        jstk_MISO <= 1'b0;
        if (len_ok && rx_b0[7:2] == LED_HDR) led_cmd <= rx_b0[1:0];
      end
    end
  end

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Directed + randomized bench for jstk_spi_responder acting as an SPI master.
module tb_jstk_spi_responder;
  import jstk_pkg::*;

  localparam int HALF = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jstk_SS = 1'b1;
  logic        jstk_SCLK = 1'b0;
  logic        jstk_MOSI = 1'b0;
  logic        jstk_MISO;
  logic [9:0]  x_pos = '0;
  logic [9:0]  y_pos = '0;
  logic [2:0]  buttons = '0;
  logic [1:0]  led_cmd;
  logic        frame_done;
  logic        frame_error;
  jstk_state_e dbg_state;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [1:0] led_at_done = 2'b00;
  logic [1:0] exp_led = 2'b00;
  logic [7:0] exp_q[$];

  jstk_spi_responder #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .jstk_SS     (jstk_SS),
    .jstk_SCLK   (jstk_SCLK),
    .jstk_MOSI   (jstk_MOSI),
    .jstk_MISO   (jstk_MISO),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .buttons     (buttons),
    .led_cmd     (led_cmd),
    .frame_done  (frame_done),
    .frame_error (frame_error),
    .dbg_state   (dbg_state)
  );

  // clock / pulse monitor
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) begin
      done_cnt++;
      led_at_done = led_cmd;
    end
    if (frame_error) err_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One mode-0 bit: MOSI set after the previous fall, MISO sampled just before the rise.
  task automatic clk_bit(input logic m, output logic s);
    jstk_MOSI = m;
    repeat (HALF) @(negedge clk);
    s = jstk_MISO;
    jstk_SCLK = 1'b1;
    repeat (HALF) @(negedge clk);
    jstk_SCLK = 1'b0;
  endtask

  task automatic run_frame(input int nbits, input logic [7:0] b0, input bit rnd_tail,
                           input int chg_bit, input logic [9:0] chg_x, input string tag);
    logic [63:0] rx;
    logic        s;
    logic        m;
    logic [7:0]  got;
    logic [7:0]  e;
    int          d0;
    int          e0;
    bit          good;
    rx = '0;
    exp_q.delete();
    exp_q.push_back(8'(x_pos % 256));
    exp_q.push_back(8'(x_pos / 256));
    exp_q.push_back(8'(y_pos % 256));
    exp_q.push_back(8'(y_pos / 256));
    exp_q.push_back(8'(buttons));
    for (int k = 0; k < 3; k++) exp_q.push_back(8'h00);
    d0 = done_cnt;
    e0 = err_cnt;
    jstk_SS = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_bit) x_pos = chg_x;
      if (i < 8) m = b0[7-i];
      else       m = rnd_tail ? 1'($urandom_range(0, 1)) : 1'b0;
      clk_bit(m, s);
      rx = {rx[62:0], s};
    end
    repeat (HALF) @(negedge clk);
    jstk_SS = 1'b1;
    repeat (10) @(negedge clk);
    for (int k = 0; k < nbits / 8; k++) begin
      got = 8'(rx >> (nbits - 8 - 8 * k));
      e = exp_q.pop_front();
      chk($sformatf("%s_byte%0d", tag, k), 64'(got), 64'(e));
    end
    good = (nbits == 40);
    if (good && b0[7:2] == 6'b100000) exp_led = b0[1:0];
    chk({tag, "_done"}, 64'(done_cnt - d0), good ? 64'd1 : 64'd0);
    chk({tag, "_err"}, 64'(err_cnt - e0), good ? 64'd0 : 64'd1);
    chk({tag, "_led"}, 64'(led_cmd), 64'(exp_led));
    if (good) chk({tag, "_led_at_done"}, 64'(led_at_done), 64'(exp_led));
    chk({tag, "_miso_idle"}, 64'(jstk_MISO), 64'd0);
  endtask

  int         len_tab[6] = '{40, 40, 40, 16, 48, 33};
  logic [7:0] rb0;
  logic       sb;
  int         d0_r;
  int         e0_r;

  initial begin
    // reset
    repeat (2) @(negedge clk);
    chk("rst_miso", 64'(jstk_MISO), 64'd0);
    chk("rst_led", 64'(led_cmd), 64'd0);
    chk("rst_done", 64'(frame_done), 64'd0);
    chk("rst_err", 64'(frame_error), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(WAIT_IDLE));
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle_state", 64'(dbg_state), 64'(IDLE));

    // nominal frame
    x_pos = 10'h2A5; y_pos = 10'h13C; buttons = 3'b101;
    run_frame(40, 8'h83, 1'b0, -1, '0, "nominal");

    // bad header keeps LED value
    x_pos = 10'h0F0; y_pos = 10'h30F; buttons = 3'b010;
    run_frame(40, 8'h43, 1'b0, -1, '0, "bad_hdr");

    // short frame, then a good one
    run_frame(20, 8'h81, 1'b0, -1, '0, "short");
    run_frame(40, 8'h81, 1'b0, -1, '0, "after_short");

    // long frame
    x_pos = 10'h3FF; y_pos = 10'h3FF; buttons = 3'b111;
    run_frame(48, 8'h82, 1'b1, -1, '0, "long");

    // input change mid-frame
    x_pos = 10'h001; y_pos = 10'h155; buttons = 3'b001;
    run_frame(40, 8'h80, 1'b0, 8, 10'h3FF, "mid_change");

    // randomized frames
    for (int n = 0; n < 10; n++) begin
      x_pos = 10'($urandom_range(0, 1023));
      y_pos = 10'($urandom_range(0, 1023));
      buttons = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) rb0 = {6'b100000, 2'($urandom_range(0, 3))};
      else                           rb0 = 8'($urandom_range(0, 255));
      run_frame(len_tab[$urandom_range(0, 5)], rb0, 1'b1, -1, '0, $sformatf("rnd%0d", n));
    end

    // reset asserted in the middle of byte 2 with SS held low
    d0_r = done_cnt;
    e0_r = err_cnt;
    x_pos = 10'h3FF; y_pos = 10'h3FF; buttons = 3'b111;
    jstk_SS = 1'b0;
    for (int i = 0; i < 12; i++) clk_bit(1'b1, sb);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_led = 2'b00;
    chk("rmid_led", 64'(led_cmd), 64'd0);
    for (int i = 0; i < 12; i++) begin
      clk_bit(1'b1, sb);
      chk($sformatf("rmid_miso%0d", i), 64'(sb), 64'd0);
    end
    chk("rmid_state", 64'(dbg_state), 64'(WAIT_IDLE));
    repeat (HALF) @(negedge clk);
    jstk_SS = 1'b1;
    repeat (10) @(negedge clk);
    chk("rmid_no_done", 64'(done_cnt - d0_r), 64'd0);
    chk("rmid_no_err", 64'(err_cnt - e0_r), 64'd0);
    chk("rmid_idle", 64'(dbg_state), 64'(IDLE));
    x_pos = 10'h2A5; y_pos = 10'h13C; buttons = 3'b101;
    run_frame(40, 8'h82, 1'b0, -1, '0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
